i2c_txn_arbiter: RTL and testbench
==================================

# i2c_txn_arbiter

Shares the single `i2c` master, which drives the ADV7513 / board I2C bus, between several independent transaction requesters: the HDMI init sequencer, a runtime CSC/infoframe updater and an audio-clock reprogrammer. It performs round-robin arbitration, issues one transaction at a time through the master's START/END/ACK handshake, and retries NACKed transfers. It guards every transfer with a timeout and returns a per-requester completion pulse with status and read data. It sits between the config FSMs and the `i2c` instance, replacing their direct START/END wiring.

## Interface
- `NREQ`, 3: number of requesters (2..8).
- `RETRIES`, 3: extra attempts after a NACK (0..15).
- `TIMEOUT`, 2_000_000: cycles allowed per handshake phase (≥16).

- `iCLK` in 1: system clock (50 MHz).
- `iRST` in 1: reset; synchronous, active-high.
- `req` in NREQ: per-requester request; held high with a stable command until its `done` bit pulses.
- `req_addr` in 7*NREQ: slave address, slice i.
- `req_wlen` in NREQ: 1 means two write bytes, 0 means one.
- `req_wdata1` / `req_wdata2` in 8*NREQ each: sub-address / data.
- `req_read` in NREQ: 1 selects a read transfer.
- `done` out NREQ: one-cycle completion pulse to the granted requester.
- `status` out 2: valid with `done`; 00 ok, 01 NACK after retries exhausted, 10 timeout.
- `rdata` out 8: read byte, valid with `done` (ok read only).
- `busy` out 1: high from grant until the cycle after `done`.
- `m_addr` out 7, `m_wlen` out 1, `m_wdata1` out 8, `m_wdata2` out 8, `m_read` out 1: command to the `i2c` master, registered and stable for the whole transaction.
- `m_start` out 1: master START.
- `m_end` in 1: master END; low while the master is busy.
- `m_ack` in 1: master ACK; 1 means NACK/error, sampled when END rises.
- `m_rdata` in 8: master read data.

## Operation
- States: IDLE, START, WAIT, CHECK.
- **IDLE.** If any `req` is high, select the winner by round robin, latch its command into the `m_*` registers, load `tries`=RETRIES, clear the timer, and go to START.
- **START.** `m_start`=1. When `m_end`=0, go to WAIT and clear the timer.
- **WAIT.** `m_start`=0. When `m_end`=1, go to CHECK.
- **CHECK.**
  - `m_ack`=0: pulse `done[g]` with status 00; `rdata` takes `m_rdata` if the transfer was a read, else holds its previous value. Go to IDLE.
  - `m_ack`=1 and `tries`>0: decrement `tries`, clear the timer, go to START with the same command.
  - `m_ack`=1 and `tries`=0: pulse `done[g]` with status 01, go to IDLE.
- **Timeout.** A 21-bit-minimum counter runs in START and WAIT. Reaching TIMEOUT-1 forces `m_start`=0, pulses `done[g]` with status 10, and returns to IDLE. A timeout is not retried.
- **Round robin.** Pointer `last` is the last granted index; reset value NREQ-1, so index 0 wins first. The search starts at `last`+1 and wraps modulo NREQ. `last` updates at grant.
- **Request timing.** A `req` that drops before grant is never served. A `req` that drops after grant is ignored; the transaction completes and `done` still pulses. Command inputs are not sampled after grant.
- **Back-to-back.** A requester may hold `req` continuously; it is re-arbitrated in the IDLE cycle after `done`. Other pending requesters win first per round robin.
- **Reset.** In any state, reset forces IDLE, `m_start`=0, `done`=0, `status`=00, `rdata`=0, `busy`=0, `m_*` command regs=0, `last`=NREQ-1. An in-flight transfer is abandoned with no `done`.

## Timing
- `req` seen in IDLE at cycle n: `m_start`=1 and `busy`=1 at n+1.
- `m_end` falls at cycle k: `m_start`=0 at k+1.
- `m_end` rises at cycle j: CHECK at j+1; `done`/`status` at j+2 for a final result, or `m_start`=1 again at j+2 on retry.
- Minimum gap between two grants: 1 IDLE cycle.
- `done` is one-hot or zero, never multi-bit.

## Structure
- Package `i2c_arb_pkg`: state enum, status codes (`ST_OK`, `ST_NACK`, `ST_TMO`), packed `i2c_cmd_t` {addr[6:0], wlen, wdata1, wdata2, read}.
- Sub-module `rr_arbiter` (NREQ): combinational winner one-hot + index from `req` and `last`.
- All state/outputs in one registered process.

## Test plan
- Single request: req[1] with addr 0x39, wdata 0x98/0x03; master model ENDs low 2 cycles after START, high 20 cycles later, ack=0 → `m_start` high exactly 1 cycle after req; done[1] at END-rise+2; status 00.
- Contention: req=3'b111 held continuously → grants in order 0,1,2,0; no done ever multi-hot.
- NACK retry: RETRIES=3, ack=1 on the first 2 attempts then 0 → 3 START pulses, one done with status 00. Ack always 1 → 4 STARTs, status 01.
- Timeout: TIMEOUT=100, master never drops END → `m_start` falls and done with status 10 at cycle 100 after grant.
- Read: req_read=1, `m_rdata`=0xA5 at END rise → `rdata`=0xA5 with done.
- Reset during WAIT → next cycle all outputs at reset values, no done. Then req[0] and req[2] together → req[0] served first.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C transaction arbiter: FSM states, completion status codes
// and the latched command presented to the i2c master.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_CHECK = 2'd3
    } arb_state_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_NACK = 2'b01;
    localparam logic [1:0] ST_TMO  = 2'b10;

    typedef struct packed {
        logic [6:0] addr;
        logic       wlen;
        logic [7:0] wdata1;
        logic [7:0] wdata2;
        logic       read;
    } i2c_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans from last+1 upward, wrapping modulo NREQ,
// and returns the first asserted request as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    always_comb begin
        int k;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        k       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            k = (int'(last) + i) % NREQ;
            if (!any && req[k]) begin
                any     = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c master between NREQ requesters: round-robin grant, START/END
// handshake, NACK retries, per-phase timeout and a one-cycle done pulse with status.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transfer; grants the next requester unless done is pulsing
// S_START | m_start high, waiting for the master to drop END
// S_WAIT  | master busy, waiting for END to rise (ack/rdata captured then)
// S_CHECK | evaluate ack: finish ok, retry, or finish with NACK
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int RETRIES = 3,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic [NREQ-1:0] req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0] req_wlen,
    input  logic [8*NREQ-1:0] req_wdata1,
    input  logic [8*NREQ-1:0] req_wdata2,
    input  logic [NREQ-1:0] req_read,
    output logic [NREQ-1:0] done,
    output logic [1:0]      status,
    output logic [7:0]      rdata,
    output logic            busy,
    output logic [6:0]      m_addr,
    output logic            m_wlen,
    output logic [7:0]      m_wdata1,
    output logic [7:0]      m_wdata2,
    output logic            m_read,
    output logic            m_start,
    input  logic            m_end,
    input  logic            m_ack,
    input  logic [7:0]      m_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = ($clog2(TIMEOUT) > 21) ? $clog2(TIMEOUT) : 21;

    arb_state_t      state_q, state_d;
    i2c_cmd_t        cmd_q, sel_cmd;
    logic [NREQ-1:0] gnt, gnt_q, done_q;
    logic [IW-1:0]   gnt_idx, last_q;
    logic            any;
    logic [3:0]      tries_q;
    logic [TW-1:0]   timer_q;
    logic            ack_q;
    logic [7:0]      mrd_q;
    logic [1:0]      status_q;
    logic [7:0]      rdata_q;
    logic            tmo_hit;
    logic            grant, tmo, retry, fin_ok, fin_nack;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req     (req),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        sel_cmd.addr   = req_addr[7*gnt_idx +: 7];
        sel_cmd.wlen   = req_wlen[gnt_idx];
        sel_cmd.wdata1 = req_wdata1[8*gnt_idx +: 8];
        sel_cmd.wdata2 = req_wdata2[8*gnt_idx +: 8];
        sel_cmd.read   = req_read[gnt_idx];
    end

    assign tmo_hit = (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge iCLK) begin
        if (iRST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Timeout takes priority over a simultaneous END edge; it is never retried.
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        tmo      = 1'b0;
        retry    = 1'b0;
        fin_ok   = 1'b0;
        fin_nack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any && done_q == '0) begin
                    grant   = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = S_IDLE;
                end else if (!m_end) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = S_IDLE;
                end else if (m_end) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!ack_q) begin
                    fin_ok  = 1'b1;
                    state_d = S_IDLE;
                end else if (tries_q != 4'd0) begin
                    retry   = 1'b1;
                    state_d = S_START;
                end else begin
                    fin_nack = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_start = (state_q == S_START);
        busy    = (state_q != S_IDLE) || (done_q != '0);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cmd_q    <= '0;
            gnt_q    <= '0;
            last_q   <= IW'(NREQ - 1);
            tries_q  <= '0;
            timer_q  <= '0;
            ack_q    <= 1'b0;
            mrd_q    <= '0;
            done_q   <= '0;
            status_q <= ST_OK;
            rdata_q  <= '0;
        end else begin
            done_q <= '0;
            if (grant) begin
                cmd_q   <= sel_cmd;
                gnt_q   <= gnt;
                last_q  <= gnt_idx;
                tries_q <= 4'(RETRIES);
            end
            if (grant || retry || (state_q == S_START && !m_end))
                timer_q <= '0;
            else if (state_q == S_START || state_q == S_WAIT)
                timer_q <= timer_q + 1'b1;
            if (state_q == S_WAIT && m_end) begin
                ack_q <= m_ack;
                mrd_q <= m_rdata;
            end
            if (retry)
                tries_q <= tries_q - 1'b1;
            if (fin_ok) begin
                done_q   <= gnt_q;
                status_q <= ST_OK;
                if (cmd_q.read)
                    rdata_q <= mrd_q;
            end
            if (fin_nack) begin
                done_q   <= gnt_q;
                status_q <= ST_NACK;
            end
            if (tmo) begin
                done_q   <= gnt_q;
                status_q <= ST_TMO;
            end
        end
    end

    assign done     = done_q;
    assign status   = status_q;
    assign rdata    = rdata_q;
    assign m_addr   = cmd_q.addr;
    assign m_wlen   = cmd_q.wlen;
    assign m_wdata1 = cmd_q.wdata1;
    assign m_wdata2 = cmd_q.wdata2;
    assign m_read   = cmd_q.read;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a behavioural i2c master model
// (END low 2 cycles after START, high again 20 cycles later).
module tb_i2c_txn_arbiter;

    localparam int NREQ = 3;

    logic             iCLK, iRST;
    logic [NREQ-1:0]  req;
    logic [7*NREQ-1:0] req_addr;
    logic [NREQ-1:0]  req_wlen;
    logic [8*NREQ-1:0] req_wdata1, req_wdata2;
    logic [NREQ-1:0]  req_read;
    logic [NREQ-1:0]  done;
    logic [1:0]       status;
    logic [7:0]       rdata;
    logic             busy;
    logic [6:0]       m_addr;
    logic             m_wlen;
    logic [7:0]       m_wdata1, m_wdata2;
    logic             m_read, m_start, m_end, m_ack;
    logic [7:0]       m_rdata;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   rise_cyc = 0;
    int   nack_cnt = 0;
    int   attempt = 0;
    bit   stuck = 1'b0;
    logic [7:0] rd_val = 8'h00;
    logic prev_start = 1'b0;

    i2c_txn_arbiter #(.NREQ(NREQ), .RETRIES(3), .TIMEOUT(100)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .req        (req),
        .req_addr   (req_addr),
        .req_wlen   (req_wlen),
        .req_wdata1 (req_wdata1),
        .req_wdata2 (req_wdata2),
        .req_read   (req_read),
        .done       (done),
        .status     (status),
        .rdata      (rdata),
        .busy       (busy),
        .m_addr     (m_addr),
        .m_wlen     (m_wlen),
        .m_wdata1   (m_wdata1),
        .m_wdata2   (m_wdata2),
        .m_read     (m_read),
        .m_start    (m_start),
        .m_end      (m_end),
        .m_ack      (m_ack),
        .m_rdata    (m_rdata)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic [6:0] a, input logic wl,
                           input logic [7:0] w1, input logic [7:0] w2, input logic rd);
        req_addr[7*i +: 7]   = a;
        req_wlen[i]          = wl;
        req_wdata1[8*i +: 8] = w1;
        req_wdata2[8*i +: 8] = w2;
        req_read[i]          = rd;
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        @(posedge iCLK); #1;
        iRST = 1'b0;
        attempt = 0;
    endtask

    task automatic wait_done(input int max_cyc, output logic [NREQ-1:0] d, output int at);
        d  = '0;
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge iCLK); #1;
            if (done != '0) begin
                d  = done;
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("wait_done_bound", 32'(done != '0), 32'd1);
    endtask

    // Master model: reacts to a START seen while idle.
    initial begin
        m_end = 1'b1; m_ack = 1'b0; m_rdata = 8'h00;
        forever begin
            @(posedge iCLK); #1;
            if (m_start && !stuck) begin
                repeat (2) @(posedge iCLK);
                #1 m_end = 1'b0;
                repeat (20) @(posedge iCLK);
                #1;
                m_ack   = (attempt < nack_cnt);
                attempt = attempt + 1;
                m_rdata = rd_val;
                m_end   = 1'b1;
                rise_cyc = cyc;
            end
        end
    end

    // START pulse counter and one-hot check on every done.
    initial begin
        forever begin
            @(posedge iCLK); #1;
            if (m_start && !prev_start) start_cnt++;
            prev_start = m_start;
            if (done != '0) chk("done_onehot", $countones(done), 1);
        end
    end

    initial begin
        logic [NREQ-1:0] d;
        int at, n0, s0, ndone;
        bit seen;
        iRST = 1'b1; req = '0; req_addr = '0; req_wlen = '0;
        req_wdata1 = '0; req_wdata2 = '0; req_read = '0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_m_start", m_start, 0);
        chk("rst_busy",    busy,    0);
        chk("rst_done",    done,    0);
        chk("rst_status",  status,  0);
        chk("rst_rdata",   rdata,   0);
        chk("rst_m_addr",  m_addr,  0);
        iRST = 1'b0;
        @(posedge iCLK); #1;

        // single request, latency and command latch
        chk("t1_pre_start", m_start, 0);
        set_cmd(1, 7'h39, 1'b1, 8'h98, 8'h03, 1'b0);
        req[1] = 1'b1;
        @(posedge iCLK); #1;
        chk("t1_m_start", m_start, 1);
        chk("t1_busy",    busy,    1);
        chk("t1_m_addr",  m_addr,  32'h39);
        chk("t1_m_wd1",   m_wdata1, 32'h98);
        chk("t1_m_wd2",   m_wdata2, 32'h03);
        chk("t1_m_wlen",  m_wlen,  1);
        chk("t1_m_read",  m_read,  0);
        wait_done(200, d, at);
        req = '0;
        chk("t1_done",      d,      3'b010);
        chk("t1_done_time", at,     rise_cyc + 2);
        chk("t1_status",    status, 2'b00);
        chk("t1_busy_done", busy,   1);
        @(posedge iCLK); #1;
        chk("t1_busy_after", busy, 0);

        // contention, all three held continuously
        do_reset();
        for (int i = 0; i < NREQ; i++) set_cmd(i, 7'(7'h10 + i), 1'b0, 8'(8'h20 + i), 8'h00, 1'b0);
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_done(200, d, at);
            if (k == 3) req = '0;
            chk("t2_order", d, 32'(1) << (k % 3));
            chk("t2_addr",  m_addr, 32'h10 + (k % 3));
        end

        // NACK twice then ACK
        do_reset();
        nack_cnt = 2;
        s0 = start_cnt;
        set_cmd(2, 7'h72, 1'b1, 8'h15, 8'h10, 1'b0);
        req[2] = 1'b1;
        wait_done(400, d, at);
        req = '0;
        chk("t3_done",   d,      3'b100);
        chk("t3_status", status, 2'b00);
        chk("t3_starts", start_cnt - s0, 3);

        // NACK always: RETRIES+1 attempts
        nack_cnt = 99;
        attempt  = 0;
        s0 = start_cnt;
        set_cmd(0, 7'h39, 1'b1, 8'h41, 8'h10, 1'b0);
        req[0] = 1'b1;
        wait_done(400, d, at);
        req = '0;
        chk("t3n_done",   d,      3'b001);
        chk("t3n_status", status, 2'b01);
        chk("t3n_starts", start_cnt - s0, 4);
        nack_cnt = 0;

        // timeout: master never drops END
        do_reset();
        stuck = 1'b1;
        set_cmd(1, 7'h39, 1'b0, 8'h02, 8'h00, 1'b0);
        req[1] = 1'b1;
        n0 = cyc;
        repeat (100) @(posedge iCLK);
        #1;
        chk("t4_start_held", m_start, 1);
        chk("t4_no_done_yet", done, 0);
        wait_done(10, d, at);
        req = '0;
        chk("t4_done",      d,       3'b010);
        chk("t4_done_time", at,      n0 + 101);
        chk("t4_status",    status,  2'b10);
        chk("t4_start_low", m_start, 0);
        stuck = 1'b0;
        repeat (2) @(posedge iCLK);

        // read then write: rdata updates only on the read
        attempt = 0;
        rd_val = 8'hA5;
        set_cmd(0, 7'h4C, 1'b0, 8'h01, 8'h00, 1'b1);
        req[0] = 1'b1;
        wait_done(200, d, at);
        req = '0;
        chk("t5_done",   d,      3'b001);
        chk("t5_status", status, 2'b00);
        chk("t5_rdata",  rdata,  32'hA5);
        chk("t5_m_read", m_read, 1);
        rd_val = 8'h3C;
        set_cmd(1, 7'h39, 1'b1, 8'h3B, 8'h80, 1'b0);
        req[1] = 1'b1;
        wait_done(200, d, at);
        req = '0;
        chk("t5_write_done", d,     3'b010);
        chk("t5_rdata_hold", rdata, 32'hA5);

        // reset while the master is busy
        set_cmd(1, 7'h39, 1'b1, 8'h55, 8'h66, 1'b0);
        req[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge iCLK); #1;
            if (busy && !m_start) seen = 1'b1;
        end
        chk("t6_reached_wait", seen, 1);
        repeat (3) @(posedge iCLK);
        #1;
        iRST = 1'b1;
        req  = '0;
        @(posedge iCLK); #1;
        chk("t6_m_start", m_start, 0);
        chk("t6_busy",    busy,    0);
        chk("t6_done",    done,    0);
        chk("t6_status",  status,  0);
        chk("t6_rdata",   rdata,   0);
        chk("t6_m_addr",  m_addr,  0);
        chk("t6_m_wd1",   m_wdata1, 0);
        iRST = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge iCLK); #1;
            if (done != '0) ndone++;
        end
        chk("t6_no_done", ndone, 0);
        attempt = 0;
        set_cmd(0, 7'h11, 1'b0, 8'h01, 8'h00, 1'b0);
        set_cmd(2, 7'h22, 1'b0, 8'h02, 8'h00, 1'b0);
        req = 3'b101;
        wait_done(200, d, at);
        req[0] = 1'b0;
        chk("t6_first",  d, 3'b001);
        wait_done(200, d, at);
        req = '0;
        chk("t6_second", d, 3'b100);
        chk("t6_addr2",  m_addr, 32'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
